// File: rtl/wide_add_seq.sv
`default_nettype none
// ============================================================================
// Module   : wide_add_seq
// Brief    : Multi-byte add/subtract sequencer driving an external 8-bit adder
//            slice LSB-first; optional zero flag via WIDE_ADD_ZERO_FLAG_EN.
// Revision : 1.0 - initial release
// ============================================================================
module wide_add_seq #(
   parameter int NBYTES = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic                sub,
   input  logic [8*NBYTES-1:0] opA,
   input  logic [8*NBYTES-1:0] opB,
   output logic                busy,
   output logic                done,
   output logic [8*NBYTES-1:0] result,
   output logic                coutOut,
   output logic                overflow,
   output logic [7:0]          adA,
   output logic [7:0]          adB,
   output logic                adCin,
   input  logic [7:0]          adSum,
   input  logic                adCout
`ifdef WIDE_ADD_ZERO_FLAG_EN
   ,
   output logic                zeroFlag
`endif
);

   localparam int             c_IW       = (NBYTES > 1) ? $clog2(NBYTES) : 1;
   localparam logic [c_IW-1:0] c_LAST_IDX = c_IW'(NBYTES - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t                     r_state;
   logic [NBYTES-1:0][7:0]     r_a;
   logic [NBYTES-1:0][7:0]     r_b;
   logic [NBYTES-1:0][7:0]     r_result;
   logic                       r_carry;
   logic [c_IW-1:0]            r_idx;
   logic                       r_busy;
   logic                       r_done;
   logic                       r_cout;
   logic                       r_ovf;
`ifdef WIDE_ADD_ZERO_FLAG_EN
   logic                       r_nz;
   logic                       r_zero;
`endif

   logic                       w_run;
   logic                       w_ovf;

   assign w_run = (r_state == S_RUN);

   // Slice inputs are forced to zero outside RUN so the adder stays quiet.
   assign adA   = w_run ? r_a[r_idx] : 8'h00;
   assign adB   = w_run ? r_b[r_idx] : 8'h00;
   assign adCin = w_run ? r_carry    : 1'b0;

   // r_b already holds ~B for subtract, so one rule covers both operations.
   assign w_ovf = (r_a[NBYTES-1][7] == r_b[NBYTES-1][7]) && (adSum[7] != r_a[NBYTES-1][7]);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state  <= S_IDLE;
         r_a      <= '0;
         r_b      <= '0;
         r_result <= '0;
         r_carry  <= 1'b0;
         r_idx    <= '0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_cout   <= 1'b0;
         r_ovf    <= 1'b0;
`ifdef WIDE_ADD_ZERO_FLAG_EN
         r_nz     <= 1'b0;
         r_zero   <= 1'b0;
`endif
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_a      <= opA;
                  r_b      <= sub ? ~opB : opB;
                  r_carry  <= sub;
                  r_idx    <= '0;
                  r_result <= '0;
                  r_cout   <= 1'b0;
                  r_ovf    <= 1'b0;
                  r_busy   <= 1'b1;
`ifdef WIDE_ADD_ZERO_FLAG_EN
                  r_nz     <= 1'b0;
                  r_zero   <= 1'b0;
`endif
                  r_state  <= S_RUN;
               end
            end
            S_RUN: begin
               r_result[r_idx] <= adSum;
               r_carry         <= adCout;
`ifdef WIDE_ADD_ZERO_FLAG_EN
               r_nz            <= r_nz | (|adSum);
`endif
               if (r_idx == c_LAST_IDX) begin
                  r_cout  <= adCout;
                  r_ovf   <= w_ovf;
`ifdef WIDE_ADD_ZERO_FLAG_EN
                  r_zero  <= ~(r_nz | (|adSum));
`endif
                  r_idx   <= '0;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                  r_state <= S_DONE;
               end else begin
                  r_idx <= r_idx + 1'b1;
               end
            end
            S_DONE: begin
               r_done  <= 1'b0;
               r_state <= S_IDLE;
            end
            default: begin
               r_busy  <= 1'b0;
               r_done  <= 1'b0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign busy     = r_busy;
   assign done     = r_done;
   assign result   = r_result;
   assign coutOut  = r_cout;
   assign overflow = r_ovf;
`ifdef WIDE_ADD_ZERO_FLAG_EN
   assign zeroFlag = r_zero;
`endif

endmodule
`default_nettype wire

// File: tb/tb_wide_add_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_wide_add_seq
// Brief    : Self-checking bench for wide_add_seq with an 8-bit slice model
//            and a full-width arithmetic reference.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wide_add_seq;

   localparam int NB = 4;
   localparam int W  = 8 * NB;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          start = 1'b0;
   logic          sub = 1'b0;
   logic [W-1:0]  opA = '0;
   logic [W-1:0]  opB = '0;
   logic          busy, done, coutOut, overflow, adCin, adCout;
   logic [W-1:0]  result;
   logic [7:0]    adA, adB, adSum;
   logic [8:0]    w_slice;
`ifdef WIDE_ADD_ZERO_FLAG_EN
   logic          zeroFlag;
`endif

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   // External 8-bit adder slice
   assign w_slice = {1'b0, adA} + {1'b0, adB} + {8'b0, adCin};
   assign adSum   = w_slice[7:0];
   assign adCout  = w_slice[8];

   wide_add_seq #(.NBYTES(NB)) dut (
      .clk(clk), .rst(rst), .start(start), .sub(sub), .opA(opA), .opB(opB),
      .busy(busy), .done(done), .result(result), .coutOut(coutOut),
      .overflow(overflow), .adA(adA), .adB(adB), .adCin(adCin),
      .adSum(adSum), .adCout(adCout)
`ifdef WIDE_ADD_ZERO_FLAG_EN
      , .zeroFlag(zeroFlag)
`endif
   );

   function automatic void ref_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                                  output logic [W-1:0] r, output logic c, output logic o);
      if (!s) begin
         {c, r} = {1'b0, a} + {1'b0, b};
         o = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
      end else begin
         r = a - b;
         c = (a >= b);
         o = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
      end
   endfunction

   // Drives one operation and records what the DUT shows along the way.
   task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                        output logic [W-1:0] r, output logic c, output logic o,
                        output int bcnt, output int lat,
                        output logic [7:0] fa, output logic [7:0] fb, output logic fcin,
                        output logic [W-1:0] r1, output logic [W-1:0] r2, output logic dextra);
      @(negedge clk);
      opA = a; opB = b; sub = s; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      opA = $urandom; opB = $urandom; sub = 1'($urandom_range(0, 1));
      bcnt = 0; lat = 0; r2 = '0;
      fa = adA; fb = adB; fcin = adCin; r1 = result;
      for (int n = 1; n <= NB + 10; n++) begin
         if (n > 1) @(negedge clk);
         if (n == 2) r2 = result;
         if (busy) bcnt++;
         if (done) begin
            lat = n;
            break;
         end
      end
      r = result; c = coutOut; o = overflow;
      @(negedge clk);
      dextra = done;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      #1;
      n_cmp++; if ({busy, done, coutOut, overflow} !== 4'b0) begin n_bad++; $display("FAIL reset_flags: got %b want 0000", {busy, done, coutOut, overflow}); end
      n_cmp++; if (result !== '0) begin n_bad++; $display("FAIL reset_result: got %h want 0", result); end
      n_cmp++; if ({adA, adB, adCin} !== 17'b0) begin n_bad++; $display("FAIL reset_slice: got %h want 0", {adA, adB, adCin}); end
      @(negedge clk); @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic run_check(input string nm, input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
      logic [W-1:0] r, r1, r2, er;
      logic c, o, ec, eo, fcin, dx;
      logic [7:0] fa, fb;
      int bc, lat;
      ref_op(a, b, s, er, ec, eo);
      do_op(a, b, s, r, c, o, bc, lat, fa, fb, fcin, r1, r2, dx);
      n_cmp++; if (r !== er) begin n_bad++; $display("FAIL %s result: got %h want %h", nm, r, er); end
      n_cmp++; if (c !== ec) begin n_bad++; $display("FAIL %s cout: got %b want %b", nm, c, ec); end
      n_cmp++; if (o !== eo) begin n_bad++; $display("FAIL %s overflow: got %b want %b", nm, o, eo); end
      n_cmp++; if (bc !== NB) begin n_bad++; $display("FAIL %s busy_cycles: got %0d want %0d", nm, bc, NB); end
      n_cmp++; if (lat !== NB + 1) begin n_bad++; $display("FAIL %s latency: got %0d want %0d", nm, lat, NB + 1); end
      n_cmp++; if (dx !== 1'b0) begin n_bad++; $display("FAIL %s done_width: got %b want 0", nm, dx); end
      n_cmp++; if (fa !== a[7:0] || fb !== (s ? ~b[7:0] : b[7:0]) || fcin !== s) begin
         n_bad++; $display("FAIL %s first_slice: got %h/%h/%b want %h/%h/%b", nm, fa, fb, fcin, a[7:0], s ? ~b[7:0] : b[7:0], s); end
      n_cmp++; if (r1 !== '0) begin n_bad++; $display("FAIL %s cleared_at_start: got %h want 0", nm, r1); end
      n_cmp++; if (r2[7:0] !== er[7:0]) begin n_bad++; $display("FAIL %s partial_byte0: got %h want %h", nm, r2[7:0], er[7:0]); end
`ifdef WIDE_ADD_ZERO_FLAG_EN
      n_cmp++; if (zeroFlag !== (er == '0)) begin n_bad++; $display("FAIL %s zeroflag: got %b want %b", nm, zeroFlag, (er == '0)); end
`endif
   endtask

   task automatic test_directed;
      run_check("add_ff_1",  32'h000000FF, 32'h00000001, 1'b0);
      run_check("add_ripple", 32'hFFFFFFFF, 32'h00000001, 1'b0);
      run_check("sub_5_7",   32'h00000005, 32'h00000007, 1'b1);
      run_check("add_ovf",   32'h7FFFFFFF, 32'h00000001, 1'b0);
      run_check("sub_ovf",   32'h80000000, 32'h00000001, 1'b1);
   endtask

   task automatic test_random;
      logic [W-1:0] a, b;
      for (int i = 0; i < 24; i++) begin
         a = $urandom;
         b = $urandom;
         if ($urandom_range(0, 3) == 0) a = {1'b0, {(W-1){1'b1}}};
         if ($urandom_range(0, 3) == 0) b = {W{1'b1}};
         if ($urandom_range(0, 5) == 0) b = a;
         run_check("random", a, b, 1'($urandom_range(0, 1)));
      end
   endtask

   task automatic test_ignore_start;
      logic [W-1:0] er, held;
      logic ec, eo;
      int lat;
      ref_op(32'h01020304, 32'h10203040, 1'b0, er, ec, eo);
      @(negedge clk);
      opA = 32'h01020304; opB = 32'h10203040; sub = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      opA = 32'hDEADBEEF; opB = 32'h12345678; sub = 1'b1; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      lat = 0;
      for (int n = 0; n < NB + 8; n++) begin
         if (done) begin lat = 1; break; end
         @(negedge clk);
      end
      n_cmp++; if (lat !== 1) begin n_bad++; $display("FAIL ignore_done_seen: got %0d want 1", lat); end
      n_cmp++; if (result !== er) begin n_bad++; $display("FAIL ignore_result: got %h want %h", result, er); end
      held = result;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL start_in_done: got busy %b want 0", busy); end
      n_cmp++; if (result !== er) begin n_bad++; $display("FAIL hold_result: got %h want %h", result, held); end
      n_cmp++; if ({adA, adB, adCin} !== 17'b0) begin n_bad++; $display("FAIL idle_slice: got %h want 0", {adA, adB, adCin}); end
   endtask

   task automatic test_reset_mid_run;
      int dseen;
      @(negedge clk);
      opA = 32'h11111111; opB = 32'h22222222; sub = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      #1;
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL abort_busy: got %b want 0", busy); end
      n_cmp++; if (result !== '0) begin n_bad++; $display("FAIL abort_result: got %h want 0", result); end
      @(negedge clk);
      rst = 1'b0;
      dseen = 0;
      for (int n = 0; n < NB + 4; n++) begin
         @(negedge clk);
         if (done || busy) dseen++;
      end
      n_cmp++; if (dseen !== 0) begin n_bad++; $display("FAIL abort_no_done: got %0d activity cycles want 0", dseen); end
      run_check("after_abort", 32'hCAFEF00D, 32'h0BADF00D, 1'b1);
   endtask

`ifdef WIDE_ADD_ZERO_FLAG_EN
   task automatic test_zero_flag;
      run_check("zf_sub_equal", 32'h12345678, 32'h12345678, 1'b1);
      n_cmp++; if (zeroFlag !== 1'b1) begin n_bad++; $display("FAIL zf_set: got %b want 1", zeroFlag); end
      run_check("zf_add_1", 32'h00000001, 32'h00000000, 1'b0);
      n_cmp++; if (zeroFlag !== 1'b0) begin n_bad++; $display("FAIL zf_clear: got %b want 0", zeroFlag); end
   endtask
`endif

   initial begin
      test_reset();
      test_directed();
      test_random();
      test_ignore_start();
      test_reset_mid_run();
`ifdef WIDE_ADD_ZERO_FLAG_EN
      test_zero_flag();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
